// File: rtl/synapse_wb_pkg.sv
// synapse_wb_pkg: shared types and constants for the synapse Wishbone initiator.
//   state_e        - initiator FSM states
//   SEL_ALL        - byte-select value driven on every beat (full word)
//   NUM_MACRO_DEF  - default width of the synapse vector
//   BASE_ADDR_DEF  - default address used when cmd_addr_sel=0
package synapse_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [3:0]  SEL_ALL       = 4'hF;
    localparam int          NUM_MACRO_DEF = 16;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h3000_000C;

endpackage

// File: rtl/synapse_wb_if.sv
// synapse_wb_if: command/response channel plus Wishbone classic master bus.
//   master modport - seen by the initiator (drives cmd_ready, wbm_*_o, rsp_*, busy)
//   slave  modport - seen by the command source / Wishbone target
interface synapse_wb_if #(
    parameter int NUM_MACRO = synapse_wb_pkg::NUM_MACRO_DEF
);
    // command channel
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_we;
    logic                 cmd_addr_sel;
    logic [31:0]          cmd_addr;
    logic [3:0]           cmd_len;
    logic [NUM_MACRO-1:0] cmd_wdata;
    // Wishbone classic master
    logic                 wbm_cyc_o;
    logic                 wbm_stb_o;
    logic                 wbm_we_o;
    logic [3:0]           wbm_sel_o;
    logic [31:0]          wbm_adr_o;
    logic [31:0]          wbm_dat_o;
    logic [31:0]          wbm_dat_i;
    logic                 wbm_ack_i;
    // response channel
    logic                 rsp_valid;
    logic [NUM_MACRO-1:0] rsp_data;
    logic                 rsp_err;
    logic                 rsp_last;
    logic                 busy;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr_sel, cmd_addr, cmd_len, cmd_wdata,
        input  wbm_dat_i, wbm_ack_i,
        output cmd_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output rsp_valid, rsp_data, rsp_err, rsp_last, busy
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr_sel, cmd_addr, cmd_len, cmd_wdata,
        output wbm_dat_i, wbm_ack_i,
        input  cmd_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  rsp_valid, rsp_data, rsp_err, rsp_last, busy
    );
endinterface

// File: rtl/synapse_wb_timeout.sv
// synapse_wb_timeout: per-beat ack watchdog.
//   clk, rst  - clock, synchronous active-high reset
//   active    - high while the initiator is waiting for ack; low clears the count
//   expired   - high in the TIMEOUT_CYCLES-th consecutive active cycle
module synapse_wb_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter idles at 0 outside ACCESS, so every beat starts from a clean count.
    always_comb begin
        cnt_d = '0;
        if (active) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = active && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/synapse_wb_initiator.sv
// synapse_wb_initiator: turns a single command into a 1..16 beat Wishbone
// classic burst of word accesses and returns one response pulse per beat.
//   wb_clk_i  - clock
//   wb_rst_i  - synchronous active-high reset; all outputs forced to 0 while high
//   bus       - synapse_wb_if.master: cmd_* handshake in, wbm_* bus, rsp_* out, busy
// Optional feature: define SYNAPSE_WBM_TIMEOUT_EN to abort a beat whose ack
// has not arrived after TIMEOUT_CYCLES cycles (response flagged rsp_err).
module synapse_wb_initiator
    import synapse_wb_pkg::*;
#(
    parameter int          NUM_MACRO      = NUM_MACRO_DEF,
    parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEF,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    synapse_wb_if.master bus
);
    if (NUM_MACRO < 1 || NUM_MACRO > 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("synapse_wb_initiator: NUM_MACRO must be 1..32 and TIMEOUT_CYCLES >= 1");
    end

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [31:0]          addr_q, addr_d;     // resolved start address
    logic [3:0]           len_q, len_d;
    logic [NUM_MACRO-1:0] wdata_q, wdata_d;
    logic [3:0]           beat_q, beat_d;
    logic [NUM_MACRO-1:0] data_q, data_d;
    logic                 err_q, err_d;

    logic timeout_hit;
    logic run, in_access, in_resp, is_last;

    assign run       = !wb_rst_i;
    assign in_access = run && (state_q == ST_ACCESS);
    assign in_resp   = run && (state_q == ST_RESP);
    // An aborted beat ends the burst regardless of how many beats remain.
    assign is_last   = err_q || (beat_q == len_q);

`ifdef SYNAPSE_WBM_TIMEOUT_EN
    synapse_wb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .active  (in_access && !bus.wbm_ack_i),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        beat_d  = beat_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    we_d    = bus.cmd_we;
                    addr_d  = bus.cmd_addr_sel ? bus.cmd_addr : BASE_ADDR;
                    len_d   = bus.cmd_len;
                    wdata_d = bus.cmd_wdata;
                    beat_d  = '0;
                    data_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // A real ack wins over a watchdog expiry in the same cycle.
                if (bus.wbm_ack_i) begin
                    data_d  = we_q ? '0 : bus.wbm_dat_i[NUM_MACRO-1:0];
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (is_last) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_d  = beat_q + 4'd1;
                    state_d = ST_ACCESS;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            beat_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign bus.cmd_ready = run && (state_q == ST_IDLE);
    assign bus.busy      = run && (state_q != ST_IDLE);

    assign bus.wbm_cyc_o = in_access;
    assign bus.wbm_stb_o = in_access;
    assign bus.wbm_we_o  = in_access && we_q;
    assign bus.wbm_sel_o = in_access ? SEL_ALL : 4'h0;
    // Word-stepped address; 32-bit add wraps naturally past 0xFFFF_FFFC.
    assign bus.wbm_adr_o = in_access ? (addr_q + {26'd0, beat_q, 2'b00}) : 32'd0;
    assign bus.wbm_dat_o = in_access ? 32'(wdata_q) : 32'd0;

    assign bus.rsp_valid = in_resp;
    assign bus.rsp_data  = in_resp ? data_q : '0;
    assign bus.rsp_last  = in_resp && is_last;
`ifdef SYNAPSE_WBM_TIMEOUT_EN
    assign bus.rsp_err   = in_resp && err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: doc/synapse_wb_initiator.md
SYNAPSE_WB_INITIATOR -- requirements
Module: synapse_wb_initiator

Interface
REQ-001 Parameter NUM_MACRO, default 16, width of the synapse bit vector (one bit per NVM macro).
REQ-002 Parameter BASE_ADDR, default 32'h3000_000C, address used when cmd_addr_sel=0.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, maximum wait for wbm_ack_i per beat; used only with the timeout feature.
REQ-004 wb_clk_i  in  1  single clock.
REQ-005 wb_rst_i  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when both valid and ready are high.
REQ-008 cmd_we  in  1  1=write, 0=read.
REQ-009 cmd_addr_sel  in  1  0=BASE_ADDR, 1=cmd_addr.
REQ-010 cmd_addr  in  32  start address.
REQ-011 cmd_len  in  4  beats minus one (1..16 beats).
REQ-012 cmd_wdata  in  NUM_MACRO  write vector, reused on every write beat (row fill).
REQ-013 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-014 wbm_sel_o  out  4;  wbm_adr_o  out  32;  wbm_dat_o  out  32.
REQ-015 wbm_dat_i  in  32;  wbm_ack_i  in  1.
REQ-016 rsp_valid  out  1  one-cycle response pulse per beat, no backpressure.
REQ-017 rsp_data  out  NUM_MACRO  wbm_dat_i[NUM_MACRO-1:0] captured on ack; 0 for writes.
REQ-018 rsp_err  out  1;  rsp_last  out  1;  busy  out  1.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS and RESP.
- IDLE: cmd_ready=1, busy=0.
- Handshake: latch all cmd fields, clear the beat counter, go to ACCESS.
REQ-020 In ACCESS the block SHALL hold wbm_cyc_o=wbm_stb_o=1, wbm_sel_o=4'hF, wbm_we_o=latched cmd_we, wbm_dat_o={zero-pad, cmd_wdata} and wbm_adr_o=start+4*beat (modulo 2^32), all stable until ack.
REQ-021 On wbm_ack_i=1 in ACCESS the block SHALL capture data and go to RESP; cyc/stb drop the following cycle.
REQ-022 In RESP the block SHALL assert rsp_valid for exactly one cycle, with rsp_last=1 when beat==cmd_len; then go to IDLE if last, else increment beat and return to ACCESS.
REQ-023 Latency:
- Handshake at cycle 0; stb high from cycle 1.
- Ack sampled at cycle N gives rsp_valid at N+1 and the next stb at N+2.
- cmd_ready rises the cycle after the last rsp_valid.
REQ-024 The block SHALL hold cmd_ready=0 and busy=1 outside IDLE; cmd_valid SHALL be ignored while busy.
REQ-025 The block SHALL ignore wbm_ack_i whenever wbm_stb_o=0.
REQ-026 With cmd_len=15 the beat counter SHALL reach 15 without wrap; the address SHALL wrap past 32'hFFFF_FFFC to 0.

Reset
REQ-027 While wb_rst_i=1, every output SHALL be 0 and the state SHALL be IDLE; cmd_ready SHALL be 1 on the first cycle after release.
REQ-028 Reset asserted mid-transaction SHALL drop cyc/stb at the next edge, emit no response, and discard all latched command state.

Configuration
REQ-029 With SYNAPSE_WBM_TIMEOUT_EN defined, a per-beat counter (cleared on ACCESS entry) SHALL force an abort when TIMEOUT_CYCLES elapse without ack:
- cyc/stb drop.
- RESP is entered with rsp_err=1, rsp_last=1 and rsp_data=0.
- Remaining beats are skipped and the FSM returns to IDLE.
REQ-030 Without SYNAPSE_WBM_TIMEOUT_EN, ACCESS SHALL wait indefinitely, rsp_err SHALL be tied to 0, and no counter logic SHALL be synthesized.

Structure
REQ-031 Package synapse_wb_pkg SHALL hold the FSM state typedef, the SEL_ALL=4'hF constant, the NUM_MACRO default and the BASE_ADDR default.
REQ-032 The timeout counter SHALL be a sub-module, synapse_wb_timeout, instantiated only under SYNAPSE_WBM_TIMEOUT_EN.

Verification
REQ-033 Single read:
- Stimulus: cmd_we=0, len=0, addr_sel=0; ack at cycle 3 with dat_i=32'h0000_A5C3.
- Response: adr=32'h3000_000C; rsp_valid at cycle 4 with rsp_data=16'hA5C3, rsp_last=1.
REQ-034 4-beat write:
- Stimulus: cmd_addr=32'h3000_0100, wdata=16'h00FF, len=3, ack after 1 wait cycle per beat.
- Response: adr sequence 0x100/0x104/0x108/0x10C with dat_o=32'h0000_00FF; 4 rsp pulses, the last with rsp_last=1.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=8):
- Stimulus: write with ack never asserted.
- Response: stb high for 8 cycles, then rsp_err=1, rsp_last=1, and cmd_ready=1 one cycle later.
REQ-036 Spurious ack and busy command:
- Stimulus: ack pulsed while idle; cmd_valid held during a burst.
- Response: no response for the idle ack; cmd_ready stays 0 until the burst completes.
REQ-037 Reset mid-burst:
- Stimulus: wb_rst_i during beat 2 of 4.
- Response: cyc/stb=0 next cycle, no further rsp_valid, and a fresh command then runs normally.
REQ-038 Address wrap:
- Stimulus: read burst from cmd_addr=32'hFFFF_FFF8, len=2.
- Response: adr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
